// File: rtl/multi_debounce.sv
// Multi-channel button/switch debouncer.
// One prescaler produces a sample tick that every channel shares. Each channel
// has a two-stage synchroniser, polarity correction, a tick-based stability
// filter, rise/fall pulses and a long-press hold flag. All outputs are registered.
module multi_debounce #(
    parameter int CHANNELS     = 2,
    parameter int TICK_DIV     = 60000,
    parameter int STABLE_TICKS = 4,
    parameter int HOLD_TICKS   = 100,
    parameter int ACTIVE_LOW   = 0,
    parameter int RESET_LEVEL  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_input,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_hold,
    output logic                o_tick
);

    // Counter widths hold the largest value each counter can reach.
    localparam int PRE_W  = (TICK_DIV > 1)     ? $clog2(TICK_DIV)       : 1;
    localparam int STAB_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS)   : 1;
    localparam int HOLD_W = (HOLD_TICKS > 0)   ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
    localparam logic              HOLD_EN   = (HOLD_TICKS != 0);

    // Pin-side reset value: the post-polarity reset level seen through the inverter.
    localparam logic              LEVEL_BIT = (RESET_LEVEL != 0);
    localparam logic              POL_BIT   = (ACTIVE_LOW != 0);
    localparam logic              SYNC_BIT  = LEVEL_BIT ^ POL_BIT;
    localparam logic [CHANNELS-1:0] POL_MASK  = {CHANNELS{POL_BIT}};
    localparam logic [CHANNELS-1:0] SYNC_INIT = {CHANNELS{SYNC_BIT}};
    localparam logic [CHANNELS-1:0] LEVEL_INIT = {CHANNELS{LEVEL_BIT}};

    // Prescaler state
    logic [PRE_W-1:0]    pre_cnt_r;
    logic [PRE_W-1:0]    pre_cnt_next_s;
    logic                tick_r;

    // Synchroniser state
    logic [CHANNELS-1:0] sync1_r;
    logic [CHANNELS-1:0] sync2_r;
    logic [CHANNELS-1:0] samp_s;

    // Filter and hold state
    logic [CHANNELS-1:0] level_r;
    logic [CHANNELS-1:0] level_next_s;
    logic [CHANNELS-1:0] accept_s;
    logic [STAB_W-1:0]   stab_r      [CHANNELS];
    logic [STAB_W-1:0]   stab_next_s [CHANNELS];
    logic [HOLD_W-1:0]   hold_cnt_r      [CHANNELS];
    logic [HOLD_W-1:0]   hold_cnt_next_s [CHANNELS];
    logic [CHANNELS-1:0] hold_next_s;

    // Output registers
    logic [CHANNELS-1:0] rise_r;
    logic [CHANNELS-1:0] fall_r;
    logic [CHANNELS-1:0] hold_r;

    // Prescaler next count: wraps from TICK_DIV-1 back to zero.
    always_comb begin
        pre_cnt_next_s = pre_cnt_r;
        if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_next_s = '0;
        end else begin
            pre_cnt_next_s = pre_cnt_r + PRE_W'(1);
        end
    end

    // Prescaler register; the tick is registered so it is high while the count sits at TICK_DIV-1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pre_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else begin
            pre_cnt_r <= pre_cnt_next_s;
            tick_r    <= (pre_cnt_next_s == PRE_LAST);
        end
    end

    // Two-flop synchroniser per channel, running every clock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_r <= SYNC_INIT;
            sync2_r <= SYNC_INIT;
        end else begin
            sync1_r <= i_input;
            sync2_r <= sync1_r;
        end
    end

    // Polarity correction after synchronisation.
    assign samp_s = sync2_r ^ POL_MASK;

    // Stability filter: a differing sample must survive STABLE_TICKS ticks without a single agreeing cycle.
    always_comb begin
        level_next_s = level_r;
        accept_s     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            stab_next_s[c] = stab_r[c];
            if (samp_s[c] == level_r[c]) begin
                stab_next_s[c] = '0;
            end else if (tick_r) begin
                if (stab_r[c] == STAB_LAST) begin
                    level_next_s[c] = samp_s[c];
                    stab_next_s[c]  = '0;
                    accept_s[c]     = 1'b1;
                end else begin
                    stab_next_s[c] = stab_r[c] + STAB_W'(1);
                end
            end else begin
                stab_next_s[c] = stab_r[c];
            end
        end
    end

    // Hold counter: counts ticks while the level is high, saturating; the flag drops with the level.
    always_comb begin
        hold_next_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hold_cnt_next_s[c] = hold_cnt_r[c];
            if (!level_r[c]) begin
                hold_cnt_next_s[c] = '0;
            end else if (tick_r && (hold_cnt_r[c] != HOLD_MAX)) begin
                hold_cnt_next_s[c] = hold_cnt_r[c] + HOLD_W'(1);
            end else begin
                hold_cnt_next_s[c] = hold_cnt_r[c];
            end
            hold_next_s[c] = HOLD_EN && level_next_s[c] && (hold_cnt_next_s[c] == HOLD_MAX);
        end
    end

    // Per-channel state and output registers; reset never creates an edge pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_r <= LEVEL_INIT;
            rise_r  <= '0;
            fall_r  <= '0;
            hold_r  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                stab_r[c]     <= '0;
                hold_cnt_r[c] <= '0;
            end
        end else begin
            level_r <= level_next_s;
            rise_r  <= accept_s & level_next_s;
            fall_r  <= accept_s & ~level_next_s;
            hold_r  <= hold_next_s;
            for (int c = 0; c < CHANNELS; c++) begin
                stab_r[c]     <= stab_next_s[c];
                hold_cnt_r[c] <= hold_cnt_next_s[c];
            end
        end
    end

    assign o_level = level_r;
    assign o_rise  = rise_r;
    assign o_fall  = fall_r;
    assign o_hold  = hold_r;
    assign o_tick  = tick_r;

endmodule

// File: tb/tb_multi_debounce.sv
// Self-checking bench for multi_debounce: directed scenarios plus randomised
// pin activity compared against a tick-counting reference model.
module tb_multi_debounce;

    localparam int TD = 4;
    localparam int ST = 3;
    localparam int HT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pin;
    logic [1:0] al_pin;
    logic [1:0] level, rise, fall, hold;
    logic       tick;
    logic [1:0] al_level, al_rise, al_fall, al_hold;
    logic       al_tick;

    int checks   = 0;
    int failures = 0;

    // Reference model state (main instance, active-high pins, reset level 0)
    int         cyc;
    int         run_start [2];
    int         rise_cyc  [2];
    logic [1:0] m_sync1, m_sync2, m_level, m_rise, m_fall, m_hold;
    logic       m_tick;

    always #5 clk = ~clk;

    multi_debounce #(.CHANNELS(2), .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLD_TICKS(HT),
                     .ACTIVE_LOW(0), .RESET_LEVEL(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_input(pin),
        .o_level(level), .o_rise(rise), .o_fall(fall), .o_hold(hold), .o_tick(tick));

    multi_debounce #(.CHANNELS(2), .TICK_DIV(TD), .STABLE_TICKS(ST), .HOLD_TICKS(HT),
                     .ACTIVE_LOW(1), .RESET_LEVEL(0)) u_al (
        .i_clk(clk), .i_rst(rst), .i_input(al_pin),
        .o_level(al_level), .o_rise(al_rise), .o_fall(al_fall), .o_hold(al_hold), .o_tick(al_tick));

    // Number of tick cycles (cycle index a multiple of TD) within cycles a..b.
    function automatic int ticks_in(input int a, input int b);
        if (b < a) return 0;
        return (b / TD) - ((a - 1) / TD);
    endfunction

    // Advance the model across one clock edge. cyc is the index of the cycle
    // now ending; cycle 1 is the first cycle after a reset edge.
    task automatic model_edge(input logic [1:0] p, input logic r);
        int   n;
        logic sv;
        if (r) begin
            cyc = 1;
            m_sync1 = 2'b00; m_sync2 = 2'b00;
            m_level = 2'b00; m_rise = 2'b00; m_fall = 2'b00; m_hold = 2'b00;
            m_tick = 1'b0;
            for (int c = 0; c < 2; c++) begin
                run_start[c] = 1;
                rise_cyc[c]  = 1;
            end
        end else begin
            n = cyc;
            for (int c = 0; c < 2; c++) begin
                sv = m_sync2[c];
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (sv == m_level[c]) begin
                    run_start[c] = n + 1;
                end else if (ticks_in(run_start[c], n) >= ST) begin
                    m_level[c]   = sv;
                    m_rise[c]    = sv;
                    m_fall[c]    = !sv;
                    run_start[c] = n + 1;
                    if (sv) rise_cyc[c] = n + 1;
                end
                m_hold[c] = m_level[c] && (ticks_in(rise_cyc[c], n) >= HT);
            end
            m_sync2 = m_sync1;
            m_sync1 = p;
            cyc     = n + 1;
            m_tick  = ((cyc % TD) == 0);
        end
    endtask

    // Drive one cycle of stimulus, clock it, update the model, settle.
    task automatic step(input logic [1:0] p, input logic r);
        pin = p;
        rst = r;
        @(posedge clk);
        model_edge(p, r);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b1);
            got = {level, rise, fall, hold, tick};
            checks++;
            if (got !== 9'd0) begin
                failures++;
                $display("FAIL reset_outputs i=%0d got=%b exp=%b", i, got, 9'd0);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            step(2'b00, 1'b0);
            checks++;
            if (tick !== ((k % 4) == 3)) begin
                failures++;
                $display("FAIL tick_period k=%0d got=%b exp=%b", k, tick, ((k % 4) == 3));
            end
        end
    endtask

    task automatic test_rise();
        int found;
        step(2'b00, 1'b1);
        step(2'b00, 1'b1);
        repeat ($urandom_range(0, 3)) step(2'b00, 1'b0);
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            step(2'b01, 1'b0);
            checks++;
            if ({level, rise, fall, hold, tick} !== {m_level, m_rise, m_fall, m_hold, m_tick}) begin
                failures++;
                $display("FAIL rise_model k=%0d got=%b exp=%b", k,
                         {level, rise, fall, hold, tick}, {m_level, m_rise, m_fall, m_hold, m_tick});
            end
            if (level[0]) found = k;
        end
        checks++;
        if (found < 11 || found > 15) begin
            failures++;
            $display("FAIL rise_latency got=%0d exp=11..15", found);
        end
        checks++;
        if ({rise, fall, level[1]} !== 5'b01_00_0) begin
            failures++;
            $display("FAIL rise_pulse got=%b exp=%b", {rise, fall, level[1]}, 5'b01_00_0);
        end
        step(2'b01, 1'b0);
        checks++;
        if ({level, rise} !== 4'b01_00) begin
            failures++;
            $display("FAIL rise_one_cycle got=%b exp=%b", {level, rise}, 4'b01_00);
        end
    endtask

    task automatic test_glitch();
        logic [1:0] p;
        step(2'b00, 1'b1);
        for (int i = 0; i < 60; i++) begin
            p = (((i / 3) % 2) == 1) ? 2'b01 : 2'b00;
            step(p, 1'b0);
            checks++;
            if ({level, rise, fall} !== 6'd0) begin
                failures++;
                $display("FAIL glitch_reject i=%0d got=%b exp=%b", i, {level, rise, fall}, 6'd0);
            end
        end
    endtask

    task automatic test_hold();
        int   lvl_t, hold_t, fell;
        logic prev_hold;
        step(2'b00, 1'b1);
        lvl_t = 0; hold_t = 0;
        for (int k = 1; k <= 80 && hold_t == 0; k++) begin
            step(2'b01, 1'b0);
            checks++;
            if ({level, rise, fall, hold} !== {m_level, m_rise, m_fall, m_hold}) begin
                failures++;
                $display("FAIL hold_model k=%0d got=%b exp=%b", k,
                         {level, rise, fall, hold}, {m_level, m_rise, m_fall, m_hold});
            end
            if (level[0] && lvl_t == 0) lvl_t = k;
            if (hold[0]) hold_t = k;
        end
        checks++;
        if (lvl_t == 0 || hold_t == 0 || (hold_t - lvl_t) < 19 || (hold_t - lvl_t) > 21) begin
            failures++;
            $display("FAIL hold_delay got=%0d exp=19..21", hold_t - lvl_t);
        end
        prev_hold = hold[0];
        fell = 0;
        for (int k = 1; k <= 40 && fell == 0; k++) begin
            step(2'b00, 1'b0);
            if (!level[0]) begin
                fell = 1;
                checks++;
                if ({fall[0], hold[0], prev_hold} !== 3'b101) begin
                    failures++;
                    $display("FAIL hold_release got=%b exp=%b", {fall[0], hold[0], prev_hold}, 3'b101);
                end
            end
            prev_hold = hold[0];
        end
        checks++;
        if (fell == 0) begin
            failures++;
            $display("FAIL hold_release_timeout got=%0d exp=%0d", fell, 1);
        end
    endtask

    task automatic test_simultaneous();
        int found;
        step(2'b00, 1'b1);
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            step(2'b11, 1'b0);
            if (rise != 2'b00) found = k;
        end
        checks++;
        if (found == 0 || rise !== 2'b11) begin
            failures++;
            $display("FAIL simul_rise got=%b exp=%b", rise, 2'b11);
        end
        step(2'b11, 1'b0);
        checks++;
        if ({level, rise} !== 4'b11_00) begin
            failures++;
            $display("FAIL simul_after got=%b exp=%b", {level, rise}, 4'b11_00);
        end
    endtask

    task automatic test_active_low();
        int found;
        al_pin = 2'b11;
        step(2'b00, 1'b1);
        step(2'b00, 1'b1);
        for (int k = 0; k < 40; k++) begin
            step(2'b00, 1'b0);
            checks++;
            if ({al_level, al_rise, al_fall, al_hold} !== 8'd0) begin
                failures++;
                $display("FAIL al_idle k=%0d got=%b exp=%b", k,
                         {al_level, al_rise, al_fall, al_hold}, 8'd0);
            end
        end
        al_pin = 2'b10;
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            step(2'b00, 1'b0);
            if (al_level[0]) found = k;
        end
        checks++;
        if (found < 11 || found > 15 || {al_rise, al_fall, al_level[1]} !== 5'b01_00_0) begin
            failures++;
            $display("FAIL al_press lat=%0d got=%b exp=%b", found,
                     {al_rise, al_fall, al_level[1]}, 5'b01_00_0);
        end
        al_pin = 2'b11;
    endtask

    task automatic test_reset_mid();
        step(2'b00, 1'b1);
        for (int j = 1; j <= 8; j++) step(2'b01, 1'b0);
        checks++;
        if (level[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_before got=%b exp=%b", level[0], 1'b0);
        end
        step(2'b01, 1'b1);
        checks++;
        if ({level, rise, fall} !== 6'd0) begin
            failures++;
            $display("FAIL mid_in_reset got=%b exp=%b", {level, rise, fall}, 6'd0);
        end
        for (int k = 1; k <= 20; k++) begin
            step(2'b01, 1'b0);
            checks++;
            if ({level[0], rise[0], fall[0]} !== {(k >= 12), (k == 12), 1'b0}) begin
                failures++;
                $display("FAIL mid_requalify k=%0d got=%b exp=%b", k,
                         {level[0], rise[0], fall[0]}, {(k >= 12), (k == 12), 1'b0});
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] p;
        logic       r;
        p = 2'b00;
        step(p, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 23) == 0) p[c] = ~p[c];
            end
            r = ($urandom_range(0, 499) == 0);
            step(p, r);
            checks++;
            if ({level, rise, fall, hold, tick} !== {m_level, m_rise, m_fall, m_hold, m_tick}) begin
                failures++;
                $display("FAIL random_model i=%0d got=%b exp=%b", i,
                         {level, rise, fall, hold, tick}, {m_level, m_rise, m_fall, m_hold, m_tick});
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        pin    = 2'b00;
        al_pin = 2'b11;
        test_reset();
        test_rise();
        test_glitch();
        test_hold();
        test_simultaneous();
        test_active_low();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
